// File: rtl/spram_port_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Command states, grant sides and RAM direction encodings.
package spram_arb_pkg;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } cmd_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_e;

  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

endpackage

// File: rtl/spram_port_arbiter_if.sv
// Client request/response ports plus the RAM macro drive bundle.
// slave = arbiter side, master = clients and RAM side.
interface spram_port_arbiter_if;
  import spram_arb_pkg::*;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rd_wrn;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr, ram_rdata,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data,
    output ram_addr, ram_wdata, ram_rd_wrn
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr, ram_rdata,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data,
    input  ram_addr, ram_wdata, ram_rd_wrn
  );

endinterface

// File: rtl/spram_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// On a tie the side that did not win last time is granted.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wr_i,
  input  logic req_rd_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  grant_e last_q, last_d;

  // Grant decode; nothing is granted while reset is held.
  always_comb begin
    gnt_wr_o = 1'b0;
    gnt_rd_o = 1'b0;
    if (!rst) begin
      if (req_wr_i && (!req_rd_i || last_q == RD))
        gnt_wr_o = 1'b1;
      else if (req_rd_i)
        gnt_rd_o = 1'b1;
    end
  end

  // A grant is always a handshake since grant implies request.
  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      gnt_wr_o: last_d = WR;
      gnt_rd_o: last_d = RD;
      default:  last_d = last_q;
    endcase
  end

  // Last-winner register; RD after reset so a first tie goes to WR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= RD;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/spram_port_arbiter.sv
// Shares one single-port RAM between a write and a read client.
// Grant -> command register -> RAM op -> response two cycles later.
module spram_port_arbiter
  import spram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  spram_port_arbiter_if.slave  bus
);

  logic          wr_hs;
  logic          rd_hs;
  cmd_e          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_pend_q, rsp_pend_d;
  logic [DW-1:0] rsp_hold_q, rsp_hold_d;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_wr_i (bus.wr_valid),
    .req_rd_i (bus.rd_valid),
    .gnt_wr_o (wr_hs),
    .gnt_rd_o (rd_hs)
  );

  assign bus.wr_ready = wr_hs;
  assign bus.rd_ready = rd_hs;

  // Next command; address/data only move on a handshake so the
  // RAM pins stay quiet in IDLE.
  always_comb begin
    cmd_d   = IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      wr_hs: begin
        cmd_d   = WRITE;
        addr_d  = bus.wr_addr;
        wdata_d = bus.wr_data;
      end
      rd_hs: begin
        cmd_d  = READ;
        addr_d = bus.rd_addr;
      end
      default: cmd_d = IDLE;
    endcase
  end

  // Response bookkeeping: RAM data is valid the cycle after READ.
  always_comb begin
    rsp_pend_d = (cmd_q == READ);
    rsp_hold_d = rsp_pend_q ? bus.ram_rdata : rsp_hold_q;
  end

  // Command and response state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_pend_q <= 1'b0;
      rsp_hold_q <= '0;
    end else begin
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_hold_q <= rsp_hold_d;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_rd_wrn = (cmd_q == WRITE) ? RAM_WR : RAM_RD;
  assign bus.rsp_valid  = rsp_pend_q;
  assign bus.rsp_data   = rsp_pend_q ? bus.ram_rdata : rsp_hold_q;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter with a behavioural RAM macro.
// Read handshakes push expected data; responses pop and compare.
module tb_spram_port_arbiter;
  import spram_arb_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   rsp_cnt;
  int   c0;
  logic [7:0] last_rsp;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [7:0] mem     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  spram_port_arbiter_if bus ();

  spram_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.ram_rd_wrn == RAM_WR)
      mem[bus.ram_addr] <= bus.ram_wdata;
    else
      bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl", {31'b0, bus.wr_ready & bus.rd_ready}, 32'd0);
      if (bus.wr_valid && bus.wr_ready)
        ref_mem[bus.wr_addr] = bus.wr_data;
      if (bus.rd_valid && bus.rd_ready)
        sb.push_back('{ref_mem[bus.rd_addr], cyc + 2});
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", {24'b0, bus.rsp_data}, {24'b0, e.data});
          chk("rsp_lat", cyc, e.due);
          last_rsp = e.data;
          rsp_cnt++;
        end
      end else begin
        chk("rsp_hold", {24'b0, bus.rsp_data}, {24'b0, last_rsp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = bus.wr_ready;
      step();
    end
    bus.wr_valid = 1'b0;
    chk("wr_acc", {31'b0, ok}, 32'd1);
  endtask

  task automatic do_rd(input logic [7:0] a);
    bit ok;
    ok = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = bus.rd_ready;
      step();
    end
    bus.rd_valid = 1'b0;
    chk("rd_acc", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wa, wd, ra;
    logic gw, gr;
    n_cmp    = 0;
    n_err    = 0;
    rsp_cnt  = 0;
    cyc      = 0;
    last_rsp = 8'h00;
    rst      = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 8'h00;
    bus.wr_data  = 8'h55;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 8'h00;

    // Reset values with both requesters already pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'b0, bus.rd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'b0, bus.rsp_data}, 32'd0);
    chk("rst_rd_wrn", {31'b0, bus.ram_rd_wrn}, 32'd1);
    chk("rst_ram_addr", {24'b0, bus.ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'b0, bus.ram_wdata}, 32'd0);
    step();
    rst = 1'b0;

    // First cycle out of reset: tie goes to WR.
    @(negedge clk);
    chk("first_wr", {31'b0, bus.wr_ready}, 32'd1);
    chk("first_rd", {31'b0, bus.rd_ready}, 32'd0);
    step();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("second_rd", {31'b0, bus.rd_ready}, 32'd1);
    chk("wr_drive_wrn", {31'b0, bus.ram_rd_wrn}, 32'd0);
    chk("wr_drive_data", {24'b0, bus.ram_wdata}, 32'h55);
    step();
    bus.rd_valid = 1'b0;

    // Write then read back 0x01.
    do_wr(8'h01, 8'hAA);
    do_rd(8'h01);
    repeat (3) step();
    chk("rd01_data", {24'b0, bus.rsp_data}, 32'hAA);

    // Both valid for six cycles: strict alternation.
    c0 = rsp_cnt;
    wa = 8'h10;
    wd = 8'hA0;
    ra = 8'h10;
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_addr  = ra;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gw = bus.wr_ready;
      gr = bus.rd_ready;
      chk("alt_wr", {31'b0, gw}, {31'b0, (i % 2) == 0});
      chk("alt_rd", {31'b0, gr}, {31'b0, (i % 2) == 1});
      step();
      if (gw) begin
        wa = wa + 8'd1;
        wd = wd + 8'd1;
        bus.wr_addr = wa;
        bus.wr_data = wd;
      end
      if (gr) begin
        ra = ra + 8'd1;
        bus.rd_addr = ra;
      end
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (3) step();
    chk("alt_rsp_cnt", rsp_cnt - c0, 32'd3);

    // Same-cycle write and read to 0x02; last grant was RD.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 8'h02;
    bus.wr_data  = 8'h5A;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 8'h02;
    @(negedge clk);
    chk("tie_wr", {31'b0, bus.wr_ready}, 32'd1);
    chk("tie_rd", {31'b0, bus.rd_ready}, 32'd0);
    step();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("tie_rd2", {31'b0, bus.rd_ready}, 32'd1);
    step();
    bus.rd_valid = 1'b0;
    repeat (3) step();
    chk("tie_rsp", {24'b0, bus.rsp_data}, 32'h5A);

    // Reset the cycle after a read handshake: response is dropped.
    c0 = rsp_cnt;
    do_rd(8'h01);
    rst = 1'b1;
    sb.delete();
    last_rsp = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    step();
    rst = 1'b0;
    chk("rst_rsp_cnt", rsp_cnt - c0, 32'd0);
    do_rd(8'h00);
    repeat (3) step();
    chk("post_rst_rd", {24'b0, bus.rsp_data}, 32'h55);

    // Read-only stream of 0x00..0x03.
    do_wr(8'h03, 8'hC3);
    step();
    c0 = rsp_cnt;
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = i[7:0];
      @(negedge clk);
      chk("rs_ready", {31'b0, bus.rd_ready}, 32'd1);
      chk("rs_wrn", {31'b0, bus.ram_rd_wrn}, 32'd1);
      step();
    end
    bus.rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_wrn_tail", {31'b0, bus.ram_rd_wrn}, 32'd1);
      step();
    end
    chk("rs_rsp_cnt", rsp_cnt - c0, 32'd4);

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spram_port_arbiter.md
# spram_port_arbiter

Shares one single-port `RAM_BLOCK` (8-bit address, 8-bit data) between an independent write requester and read requester, entirely in one clock domain. It replaces delay-line clock doubling with a round-robin arbiter and a registered command stage, giving one RAM access per cycle. Read data returns on a separate response channel with fixed latency. The block sits between the two client ports and the RAM macro.

## Interface
- `AW`, 8, address width; must match `RAM_BLOCK.ADDR`.
- `DW`, 8, data width; must match `RAM_BLOCK.WDATA`/`RDATA`.

- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock; the RAM `CLK` is tied to it externally.
- `rst`  in  1  async active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted this cycle when both `wr_valid` and `wr_ready` are high.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DW  write data.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read accepted this cycle when both `rd_valid` and `rd_ready` are high.
- `rd_addr`  in  AW  read address.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` is valid.
- `rsp_data`  out  DW  read result.
- `ram_addr`  out  AW  to `RAM_BLOCK.ADDR`.
- `ram_wdata`  out  DW  to `RAM_BLOCK.WDATA`.
- `ram_rd_wrn`  out  1  to `RAM_BLOCK.RD_WRN`; 1 = read, 0 = write.
- `ram_rdata`  in  DW  from `RAM_BLOCK.RDATA`.

## Operation
- Arbitration is combinational in cycle N, from `wr_valid`, `rd_valid` and the `last_grant` register (WR or RD).
  - Only one valid: that side gets ready.
  - Both valid: the side not in `last_grant` gets ready. Strict alternation, so neither side waits more than 1 cycle.
  - Neither valid: both readies low.
- At most one of `wr_ready`/`rd_ready` is high in any cycle.
- `last_grant` updates only on a completed handshake.
- Command register `cmd_state` has three states: IDLE, WRITE, READ. It loads on every `clk` edge:
  - WRITE on a write handshake, capturing `wr_addr` and `wr_data`.
  - READ on a read handshake, capturing `rd_addr`.
  - Otherwise IDLE.
- RAM drive outputs are registered from `cmd_state`:
  - In WRITE, `ram_rd_wrn`=0.
  - In READ and IDLE, `ram_rd_wrn`=1.
  - `ram_addr`/`ram_wdata` hold their last value in IDLE (no toggling).
- Response stage: `rsp_pending` is set for the cycle after `cmd_state`=READ. In that cycle `rsp_valid`=1 and `rsp_data`=`ram_rdata`. `rsp_data` holds its value otherwise.
- Same-address read and write:
  - Ordering follows grant order.
  - A read granted after a write to the same address returns the new data. No bypass is needed because the RAM is accessed in order.

## Timing
- Reset values:
  - `wr_ready`=0 and `rd_ready`=0 while `rst` is high.
  - `rsp_valid`=0, `rsp_data`=0.
  - `ram_rd_wrn`=1, `ram_addr`=0, `ram_wdata`=0.
  - `cmd_state`=IDLE, `last_grant`=RD (so a first-cycle tie grants WR).
- Handshake in cycle N: RAM operation is presented in N+1 and executed at the end of N+1.
- Read handshake in cycle N gives `rsp_valid` in cycle N+2. Latency is exactly 2 cycles, with no backpressure on the response.
- Throughput: one accepted request per cycle, back-to-back, under any mix.
- Requesters must hold address and data stable while valid is high and ready is low. The arbiter never drops a valid request.
- Reset asserted mid-operation: in-flight WRITE and READ are abandoned and no `rsp_valid` is issued. After deassertion the first grant occurs in the first cycle `rst` is low.

## Structure
- Shared package `spram_arb_pkg` holds:
  - the `cmd_state` enum (IDLE, WRITE, READ);
  - the grant enum (WR, RD);
  - a `RAM_RD`=1 / `RAM_WR`=0 constant pair.
- One sub-module, `rr_arb2`: the two-requester round-robin arbiter (combinational grant plus the `last_grant` register). Everything else lives in the top.

## Test plan
- Reset → all outputs take their reset values. Release reset with `wr_valid`=`rd_valid`=1 → `wr_ready`=1 in the first cycle.
- Write 0x55 to 0x00, then 0xAA to 0x01, then read 0x01 → `rsp_valid` 2 cycles after the read handshake with `rsp_data`=0xAA.
- Hold both requesters valid for 6 cycles → grants alternate WR, RD, WR, RD, WR, RD. 3 `rsp_valid` pulses appear, each 2 cycles after its grant.
- Same cycle: write 0x5A to 0x02 and read 0x02 with `last_grant`=RD → write first, read next cycle → `rsp_data`=0x5A.
- Assert `rst` the cycle after a read handshake → no `rsp_valid`. After release, reading address 0x00 returns the pre-reset content 0x55 (RAM is not cleared).
- Read-only stream of 4 reads to 0x00..0x03 after directed writes → 4 consecutive `rsp_valid` cycles with matching data. `ram_rd_wrn` stays 1 throughout.
